// File: rtl/n2r_slice_ctrl_pkg.sv
// ============================================================================
// Module : n2r_pkg
// Brief  : Shared state encoding and geometry helpers for the N2R slice path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package n2r_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } n2r_state_e;

   function automatic int slice_rows(input int block_size, input int num_cores);
      return block_size * num_cores;
   endfunction

   function automatic int chunks_per_row(input int col, input int block_size);
      return col / block_size;
   endfunction

   function automatic int num_slices(input int row, input int slice_rows_i);
      return (row + slice_rows_i - 1) / slice_rows_i;
   endfunction

   // Index width that never collapses to zero for single-entry ranges.
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/n2r_slice_ctrl_if.sv
// ============================================================================
// Module : n2r_slice_ctrl_if
// Brief  : Row stream, row-RAM, slice-register and chunk handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface n2r_slice_ctrl_if
   import n2r_pkg::*;
#(
   parameter int ROW        = 6,
   parameter int COL        = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int NUM_CORES  = 2
);

   localparam int c_aw = width_of(ROW);
   localparam int c_iw = width_of(slice_rows(BLOCK_SIZE, NUM_CORES));
   localparam int c_cw = width_of(chunks_per_row(COL, BLOCK_SIZE));

   logic            row_valid;
   logic            row_ready;
   logic            ram_we;
   logic [c_aw-1:0] ram_waddr;
   logic [c_aw-1:0] ram_raddr;
   logic            slice_we;
   logic [c_iw-1:0] slice_idx;
   logic            slice_pad;
   logic [c_cw-1:0] chunk_idx;
   logic            out_valid;
   logic            out_ready;
   logic            slice_done;

   modport master (
      input  row_valid, out_ready,
      output row_ready, ram_we, ram_waddr, ram_raddr,
             slice_we, slice_idx, slice_pad,
             chunk_idx, out_valid, slice_done
   );

   modport slave (
      output row_valid, out_ready,
      input  row_ready, ram_we, ram_waddr, ram_raddr,
             slice_we, slice_idx, slice_pad,
             chunk_idx, out_valid, slice_done
   );

endinterface

`default_nettype wire

// File: rtl/n2r_slice_ctrl_load_seq.sv
// ============================================================================
// Module : n2r_load_seq
// Brief  : LOAD-phase sequencer: row-RAM reads, delayed slice captures.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module n2r_load_seq #(
   parameter int ROW        = 6,
   parameter int AW         = 3,
   parameter int SLICE_ROWS = 4,
   parameter int IW         = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_go,
   input  logic [AW:0]   i_base,
   output logic [AW-1:0] o_raddr,
   output logic          o_slice_we,
   output logic [IW-1:0] o_slice_idx,
   output logic          o_slice_pad,
   output logic          o_last_cap
);

   localparam logic [IW-1:0] c_last_k = IW'(SLICE_ROWS - 1);

   logic          r_rd_active;
   logic [IW-1:0] r_rd_k;
   logic          r_rd_pad;
   logic [AW:0]   r_base;
   logic [AW-1:0] r_raddr;
   logic          r_cap_we;
   logic [IW-1:0] r_cap_idx;
   logic          r_cap_pad;

   logic [AW:0]   w_sel_base;
   logic [IW-1:0] w_sel_k;
   logic [31:0]   w_pos;
   logic          w_pad;
   logic [AW-1:0] w_addr;

   // Position of the read issued next cycle; rows past ROW read address 0 and are padded.
   always_comb begin
      w_sel_base = i_go ? i_base : r_base;
      w_sel_k    = i_go ? '0 : r_rd_k + IW'(1);
      w_pos      = 32'(w_sel_base) + 32'(w_sel_k);
      w_pad      = (w_pos >= 32'(ROW));
      w_addr     = w_pad ? '0 : w_pos[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_active <= 1'b0;
         r_rd_k      <= '0;
         r_rd_pad    <= 1'b0;
         r_base      <= '0;
         r_raddr     <= '0;
         r_cap_we    <= 1'b0;
         r_cap_idx   <= '0;
         r_cap_pad   <= 1'b0;
      end else begin
         r_cap_we  <= r_rd_active;
         r_cap_idx <= r_rd_active ? r_rd_k : '0;
         r_cap_pad <= r_rd_active & r_rd_pad;
         if (i_go) begin
            r_base      <= i_base;
            r_rd_active <= 1'b1;
            r_rd_k      <= '0;
            r_rd_pad    <= w_pad;
            r_raddr     <= w_addr;
         end else if (r_rd_active) begin
            if (r_rd_k == c_last_k) begin
               r_rd_active <= 1'b0;
               r_rd_k      <= '0;
               r_rd_pad    <= 1'b0;
               r_raddr     <= '0;
            end else begin
               r_rd_k   <= w_sel_k;
               r_rd_pad <= w_pad;
               r_raddr  <= w_addr;
            end
         end
      end
   end

   assign o_raddr     = r_raddr;
   assign o_slice_we  = r_cap_we;
   assign o_slice_idx = r_cap_idx;
   assign o_slice_pad = r_cap_pad;
   assign o_last_cap  = r_cap_we & (r_cap_idx == c_last_k);

endmodule

`default_nettype wire

// File: rtl/n2r_slice_ctrl.sv
// ============================================================================
// Module : n2r_slice_ctrl
// Brief  : Fill/load/drain sequencer for the normal-to-ready reshaping path.
//          Define N2R_STALL_CNT_EN to add the stall_cycles output counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module n2r_slice_ctrl
   import n2r_pkg::*;
#(
   parameter int ROW        = 6,
   parameter int COL        = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int NUM_CORES  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   n2r_slice_ctrl_if.master bus,
   output logic             busy,
   output logic             done
`ifdef N2R_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam int c_slice_rows = slice_rows(BLOCK_SIZE, NUM_CORES);
   localparam int c_chunks     = chunks_per_row(COL, BLOCK_SIZE);
   localparam int c_num_slices = num_slices(ROW, c_slice_rows);
   localparam int c_aw         = width_of(ROW);
   localparam int c_iw         = width_of(c_slice_rows);
   localparam int c_cw         = width_of(c_chunks);
   localparam int c_sw         = width_of(c_num_slices);

   localparam logic [c_aw-1:0] c_last_row   = c_aw'(ROW - 1);
   localparam logic [c_cw-1:0] c_last_chunk = c_cw'(c_chunks - 1);
   localparam logic [c_sw-1:0] c_last_slice = c_sw'(c_num_slices - 1);
   localparam logic [c_aw:0]   c_slice_step = (c_aw + 1)'(c_slice_rows);

   n2r_state_e      r_state;
   logic            r_row_ready;
   logic [c_aw-1:0] r_wr_cnt;
   logic [c_cw-1:0] r_chunk_cnt;
   logic [c_sw-1:0] r_slice_cnt;
   logic [c_aw:0]   r_slice_base;
   logic            r_out_valid;
   logic            r_busy;
   logic            r_done;

   logic            w_row_acc;
   logic            w_hs;
   logic            w_chunk_last;
   logic            w_pass_last;
   logic            w_fill_last;
   logic            w_load_go;
   logic [c_aw:0]   w_next_base;
   logic [c_aw:0]   w_load_base;
   logic [c_aw-1:0] w_raddr;
   logic            w_slice_we;
   logic [c_iw-1:0] w_slice_idx;
   logic            w_slice_pad;
   logic            w_last_cap;

   // row_ready and out_valid are only ever high in FILL and DRAIN, so they gate their states.
   assign w_row_acc    = bus.row_valid & r_row_ready;
   assign w_hs         = r_out_valid & bus.out_ready;
   assign w_chunk_last = w_hs & (r_chunk_cnt == c_last_chunk);
   assign w_pass_last  = w_chunk_last & (r_slice_cnt == c_last_slice);
   assign w_fill_last  = w_row_acc & (r_wr_cnt == c_last_row);
   assign w_load_go    = w_fill_last | (w_chunk_last & ~w_pass_last);
   assign w_next_base  = r_slice_base + c_slice_step;
   assign w_load_base  = (r_state == ST_FILL) ? '0 : w_next_base;

   n2r_load_seq #(
      .ROW        (ROW),
      .AW         (c_aw),
      .SLICE_ROWS (c_slice_rows),
      .IW         (c_iw)
   ) u_load_seq (
      .clk         (clk),
      .rst         (rst),
      .i_go        (w_load_go),
      .i_base      (w_load_base),
      .o_raddr     (w_raddr),
      .o_slice_we  (w_slice_we),
      .o_slice_idx (w_slice_idx),
      .o_slice_pad (w_slice_pad),
      .o_last_cap  (w_last_cap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_row_ready  <= 1'b0;
         r_wr_cnt     <= '0;
         r_chunk_cnt  <= '0;
         r_slice_cnt  <= '0;
         r_slice_base <= '0;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_FILL;
                  r_row_ready  <= 1'b1;
                  r_busy       <= 1'b1;
                  r_wr_cnt     <= '0;
                  r_chunk_cnt  <= '0;
                  r_slice_cnt  <= '0;
                  r_slice_base <= '0;
               end
            end
            ST_FILL: begin
               if (w_row_acc) begin
                  if (r_wr_cnt == c_last_row) begin
                     r_state     <= ST_LOAD;
                     r_row_ready <= 1'b0;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + c_aw'(1);
                  end
               end
            end
            ST_LOAD: begin
               if (w_last_cap) begin
                  r_state     <= ST_DRAIN;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_hs) begin
                  if (r_chunk_cnt == c_last_chunk) begin
                     r_chunk_cnt <= '0;
                     r_out_valid <= 1'b0;
                     // Base stops at the last slice so it cannot overflow its width.
                     if (r_slice_cnt == c_last_slice) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state      <= ST_LOAD;
                        r_slice_cnt  <= r_slice_cnt + c_sw'(1);
                        r_slice_base <= w_next_base;
                     end
                  end else begin
                     r_chunk_cnt <= r_chunk_cnt + c_cw'(1);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_row_ready <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef N2R_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`endif

   assign bus.row_ready  = r_row_ready;
   assign bus.ram_we     = w_row_acc;
   assign bus.ram_waddr  = r_wr_cnt;
   assign bus.ram_raddr  = w_raddr;
   assign bus.slice_we   = w_slice_we;
   assign bus.slice_idx  = w_slice_idx;
   assign bus.slice_pad  = w_slice_pad;
   assign bus.chunk_idx  = r_chunk_cnt;
   assign bus.out_valid  = r_out_valid;
   assign bus.slice_done = w_chunk_last;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_n2r_slice_ctrl.sv
// ============================================================================
// Module : tb_n2r_slice_ctrl
// Brief  : Scoreboard bench for n2r_slice_ctrl (optionally N2R_STALL_CNT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_n2r_slice_ctrl;
   import n2r_pkg::*;

   localparam int ROW = 6;
   localparam int COL = 8;
   localparam int BS  = 2;
   localparam int NC  = 2;
   localparam int SR  = slice_rows(BS, NC);
   localparam int CPR = chunks_per_row(COL, BS);
   localparam int NS  = num_slices(ROW, SR);

   typedef struct {int idx; int pad; int raddr;} cap_t;
   typedef struct {int idx; int sd;} chunk_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic busy;
   logic done;
`ifdef N2R_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   n2r_slice_ctrl_if #(.ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .NUM_CORES(NC)) bus ();

   n2r_slice_ctrl #(.ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .NUM_CORES(NC)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
`ifdef N2R_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     exp_waddr[$];
   cap_t   exp_cap[$];
   chunk_t exp_chunk[$];
   int     cyc = 0;
   int     t_acc = 0;
   int     t_sd = -100;
   bit     lat_pending = 1'b0;
   bit     done_pending = 1'b0;
   int     done_count = 0;
   logic [31:0] prev_raddr = '0;
   int     m_ew;
   cap_t   m_cap;
   chunk_t m_chunk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle();
      check_eq("rst_row_ready", 32'(bus.row_ready), 0);
      check_eq("rst_ram_we", 32'(bus.ram_we), 0);
      check_eq("rst_ram_waddr", 32'(bus.ram_waddr), 0);
      check_eq("rst_ram_raddr", 32'(bus.ram_raddr), 0);
      check_eq("rst_slice_we", 32'(bus.slice_we), 0);
      check_eq("rst_slice_idx", 32'(bus.slice_idx), 0);
      check_eq("rst_slice_pad", 32'(bus.slice_pad), 0);
      check_eq("rst_chunk_idx", 32'(bus.chunk_idx), 0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 0);
      check_eq("rst_slice_done", 32'(bus.slice_done), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
   endtask

   task automatic push_pass();
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < SR; k++) begin
            cap_t ce;
            int   pos;
            pos      = s * SR + k;
            ce.idx   = k;
            ce.pad   = (pos >= ROW) ? 1 : 0;
            ce.raddr = (pos >= ROW) ? 0 : pos;
            exp_cap.push_back(ce);
         end
         for (int c = 0; c < CPR; c++) begin
            chunk_t he;
            he.idx = c;
            he.sd  = (c == CPR - 1) ? 1 : 0;
            exp_chunk.push_back(he);
         end
      end
      done_pending = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_to_row_ready", 32'(bus.row_ready), 1);
   endtask

   task automatic fill_rows(input bit stray_start);
      for (int r = 0; r < ROW; r++) begin
         if (stray_start && r == 2) begin
            bus.row_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         bus.row_valid = 1'b1;
         exp_waddr.push_back(r);
         tick();
      end
      bus.row_valid = 1'b0;
      check_eq("load_busy", 32'(busy), 1);
      check_eq("load_row_ready", 32'(bus.row_ready), 0);
      check_eq("load_out_valid", 32'(bus.out_valid), 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check_eq("done_seen", 32'(done), 1);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.out_valid && n < budget) begin
         tick();
         n++;
      end
      check_eq("out_valid_seen", 32'(bus.out_valid), 1);
   endtask

   // Scoreboard monitor: everything the DUT emits is matched against the queues.
   always @(negedge clk) begin
      cyc++;
      if (bus.ram_we) begin
         if (exp_waddr.size() == 0) begin
            check_eq("unexpected_ram_we", 32'(bus.ram_we), 0);
         end else begin
            m_ew = exp_waddr.pop_front();
            check_eq("ram_waddr", 32'(bus.ram_waddr), m_ew);
            if (m_ew == ROW - 1) begin
               lat_pending = 1'b1;
               t_acc = cyc;
            end
         end
      end
      if (bus.slice_we) begin
         if (exp_cap.size() == 0) begin
            check_eq("unexpected_slice_we", 32'(bus.slice_we), 0);
         end else begin
            m_cap = exp_cap.pop_front();
            check_eq("slice_idx", 32'(bus.slice_idx), m_cap.idx);
            check_eq("slice_pad", 32'(bus.slice_pad), m_cap.pad);
            check_eq("ram_raddr", prev_raddr, m_cap.raddr);
         end
      end
      if (bus.out_valid) begin
         if (lat_pending) begin
            check_eq("fill_to_valid_latency", cyc - t_acc, SR + 2);
            lat_pending = 1'b0;
         end
         if (exp_chunk.size() == 0) begin
            check_eq("unexpected_out_valid", 32'(bus.out_valid), 0);
         end else if (bus.out_ready) begin
            m_chunk = exp_chunk.pop_front();
            check_eq("chunk_idx", 32'(bus.chunk_idx), m_chunk.idx);
            check_eq("slice_done", 32'(bus.slice_done), m_chunk.sd);
            if (m_chunk.sd != 0) t_sd = cyc;
         end else begin
            check_eq("chunk_hold", 32'(bus.chunk_idx), exp_chunk[0].idx);
            check_eq("stall_slice_done", 32'(bus.slice_done), 0);
         end
      end else if (bus.slice_done) begin
         check_eq("stray_slice_done", 32'(bus.slice_done), 0);
      end
      if (done) begin
         check_eq("done_expected", 32'(done_pending), 1);
         check_eq("done_after_slice_done", cyc - t_sd, 1);
         done_pending = 1'b0;
         done_count++;
      end
      prev_raddr = 32'(bus.ram_raddr);
   end

   initial begin
      int n;
      bus.row_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_idle();
`ifdef N2R_STALL_CNT_EN
      check_eq("rst_stall_cycles", stall_cycles, 0);
`endif
      rst = 1'b0;
      tick();
      check_eq("idle_busy", 32'(busy), 0);

      // Pass 1: out_ready held high, one chunk per cycle.
      push_pass();
      do_start();
      fill_rows(1'b0);
      check_eq("load_first_raddr", 32'(bus.ram_raddr), 0);
      wait_done(200);
`ifdef N2R_STALL_CNT_EN
      check_eq("stall_pass1", stall_cycles, 0);
`endif
      tick();
      check_eq("busy_after_done", 32'(busy), 0);
      check_eq("done_one_cycle", 32'(done), 0);

      // Pass 2: stray start in FILL, out_ready 1,0,0,1 in DRAIN.
      push_pass();
      do_start();
      fill_rows(1'b1);
      wait_valid(50);
      tick();
      bus.out_ready = 1'b0;
      check_eq("hold_chunk_a", 32'(bus.chunk_idx), 1);
      tick();
      check_eq("hold_chunk_b", 32'(bus.chunk_idx), 1);
      tick();
      bus.out_ready = 1'b1;
      wait_done(200);
`ifdef N2R_STALL_CNT_EN
      check_eq("stall_at_done", stall_cycles, 2);
`endif
      tick();
`ifdef N2R_STALL_CNT_EN
      check_eq("stall_hold", stall_cycles, 2);
`endif
      check_eq("busy_after_done2", 32'(busy), 0);

      // Pass 3: reset at chunk 2 of slice 0.
      push_pass();
      do_start();
      fill_rows(1'b0);
      n = 0;
      while (!(bus.out_valid && bus.chunk_idx == 2) && n < 60) begin
         tick();
         n++;
      end
      check_eq("reach_chunk2", 32'(bus.chunk_idx), 2);
      rst = 1'b1;
      tick();
      check_idle();
      exp_cap.delete();
      exp_chunk.delete();
      done_pending = 1'b0;
      lat_pending  = 1'b0;
      rst = 1'b0;

      // row_valid in IDLE must be ignored.
      bus.row_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("idle_ram_we", 32'(bus.ram_we), 0);
         check_eq("idle_row_ready", 32'(bus.row_ready), 0);
      end
      bus.row_valid = 1'b0;

      // Pass 4: fresh pass replays from address 0.
      push_pass();
      do_start();
      fill_rows(1'b0);
      wait_done(200);
`ifdef N2R_STALL_CNT_EN
      check_eq("stall_pass4", stall_cycles, 0);
`endif
      tick();
      check_eq("busy_after_done4", 32'(busy), 0);

      check_eq("waddr_queue_empty", exp_waddr.size(), 0);
      check_eq("cap_queue_empty", exp_cap.size(), 0);
      check_eq("chunk_queue_empty", exp_chunk.size(), 0);
      check_eq("done_count", done_count, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/n2r_slice_ctrl.md
Name: n2r_slice_ctrl

Overview:
- Controller that sequences the normal-to-ready reshaping datapath feeding the Multi-MAC array.
- Accepts a row-by-row matrix stream and generates the row-RAM write addresses.
- Then walks the stored matrix one slice (BLOCK_SIZE*NUM_CORES rows) at a time, issuing RAM reads, slice-register capture strobes and chunk indices.
- Presents chunks to the MAC array under a valid/ready handshake and owns all fill/load/drain sequencing; the datapath holds only RAM, slice registers and muxes.

Parameters:
- ROW, 6, matrix rows stored per pass.
- COL, 8, matrix columns per row.
- BLOCK_SIZE, 2, systolic block dimension; must divide COL.
- NUM_CORES, 2, MAC cores fed in parallel.
- Derived constants:
  - SLICE_ROWS = BLOCK_SIZE*NUM_CORES
  - CHUNKS_PER_ROW = COL/BLOCK_SIZE
  - NUM_SLICES = ceil(ROW/SLICE_ROWS)
  - AW = $clog2(ROW)

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin one pass; sampled only in IDLE.
- row_valid  in  1  upstream row present.
- row_ready  out  1  controller accepts row (FILL only).
- ram_we  out  1  row-RAM write enable.
- ram_waddr  out  AW  row-RAM write address.
- ram_raddr  out  AW  row-RAM read address (1-cycle RAM read latency).
- slice_we  out  1  capture ram_dout into slice register slice_idx.
- slice_idx  out  $clog2(SLICE_ROWS)  slice register index being written.
- slice_pad  out  1  with slice_we: load zeros instead of ram_dout.
- chunk_idx  out  $clog2(CHUNKS_PER_ROW)  column chunk selected for output mux.
- out_valid  out  1  chunk available to MAC array.
- out_ready  in  1  MAC array accepts chunk.
- slice_done  out  1  one-cycle pulse on last chunk handshake of a slice.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, pass complete.

Behaviour:
- Reset: state=IDLE. Every output is 0 (row_ready, ram_we, ram_waddr, ram_raddr, slice_we, slice_idx, slice_pad, chunk_idx, out_valid, slice_done, busy, done). All counters are cleared.
- Reset asserted in any state: return to IDLE next cycle; partial pass discarded; no done pulse.
- IDLE: start=1 -> FILL next cycle. No other input is observed.
- FILL:
  - row_ready=1.
  - ram_we = row_valid & row_ready (combinational); ram_waddr = wr_cnt.
  - wr_cnt increments per accepted row.
  - Acceptance of row ROW-1 -> LOAD next cycle; row_ready drops in the same transition.
- LOAD (SLICE_ROWS+1 cycles):
  - Cycle k=0..SLICE_ROWS-1: ram_raddr = slice_base+k when slice_base+k < ROW, else 0.
  - Cycle k+1: slice_we=1, slice_idx=k, slice_pad=1 iff slice_base+k >= ROW.
  - After the capture of idx SLICE_ROWS-1 -> DRAIN.
- DRAIN:
  - out_valid=1; chunk_idx = chunk_cnt.
  - chunk_cnt advances only on out_valid&out_ready. chunk_idx is stable while out_ready=0.
  - On handshake with chunk_cnt = CHUNKS_PER_ROW-1:
    - slice_done=1 that cycle, chunk_cnt->0, slice_base += SLICE_ROWS.
    - If that was slice NUM_SLICES-1 -> DONE, else -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- Latencies:
  - start to row_ready = 1 cycle.
  - Last row accept to first out_valid = SLICE_ROWS+2 cycles.
- Width rules: counters saturate at their terminal value; there is no wrap. slice_base is AW+1 bits so padded addresses never alias.
- Boundary cases:
  - start while busy is ignored.
  - row_valid outside FILL is ignored (row_ready=0).
  - out_ready held high gives one chunk per cycle.
  - ROW a multiple of SLICE_ROWS produces no slice_pad.

Optional Feature:
- Macro: N2R_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Counts DRAIN cycles with out_valid=1 & out_ready=0.
  - Cleared on rst and on start acceptance; saturates at 2^32-1; holds after done.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared package n2r_pkg holds:
  - the state encoding (IDLE, FILL, LOAD, DRAIN, DONE) as a typedef enum;
  - functions computing SLICE_ROWS, CHUNKS_PER_ROW and NUM_SLICES, shared with the datapath and the bench.
- One natural sub-module: n2r_load_seq, the LOAD-phase read/capture sequencer (raddr, 1-cycle-delayed slice_we/slice_idx/slice_pad, last-capture flag).

Test Plan:
- Reset then start, row_valid held high 6 cycles -> ram_we high 6 cycles with ram_waddr 0..5; state LOAD on the cycle after row 5.
- Defaults, out_ready=1 -> slice 0 gives slice_we idx 0..3, raddr 0..3, slice_pad=0, then chunk_idx 0,1,2,3 on consecutive cycles with slice_done on chunk 3.
- Slice 1 -> raddr 4,5,0,0 with slice_pad 0,0,1,1; done pulses once, 1 cycle after the second slice_done; busy then 0.
- out_ready toggled 1,0,0,1 during DRAIN -> chunk_idx holds during the 0 cycles. With N2R_STALL_CNT_EN, stall_cycles=2 at done.
- rst asserted mid-DRAIN (chunk 2 of slice 0) -> next cycle all outputs 0, busy=0, no done. A fresh start then replays from ram_waddr 0.
- start pulsed during FILL, and row_valid asserted in IDLE -> no effect: wr_cnt is unchanged and ram_we stays 0 in IDLE.
